// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the C17 BIST controller and its MISR.
package c17_bist_pkg;

    localparam int unsigned NIN    = 5;
    localparam int unsigned NOUT   = 2;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned N_EXH  = 32;
    localparam int unsigned N_LFSR = 31;

    localparam int unsigned MISR_TAP_A = 15;
    localparam int unsigned MISR_TAP_B = 13;
    localparam int unsigned MISR_TAP_C = 12;
    localparam int unsigned MISR_TAP_D = 10;

    localparam int unsigned LFSR_TAP_HI = 4;
    localparam int unsigned LFSR_TAP_LO = 2;

    localparam logic [NIN-1:0] LFSR_SEED = NIN'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CAPTURE,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // x^5+x^3+1 Fibonacci step; maximal length, never reaches zero from a nonzero seed.
    function automatic logic [NIN-1:0] lfsr_next(input logic [NIN-1:0] p);
        return {p[NIN-2:0], p[LFSR_TAP_HI] ^ p[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register compacting the C17 response into a signature.
module c17_misr
    import c17_bist_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [NOUT-1:0] data_i,
    output logic [W-1:0]    sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic         fb_c;

    assign fb_c = sig_q[MISR_TAP_A] ^ sig_q[MISR_TAP_B] ^ sig_q[MISR_TAP_C] ^ sig_q[MISR_TAP_D];

    // Clear has priority so a new run always starts from an all-zero signature.
    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[W-2:0], fb_c} ^ W'(data_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller: applies exhaustive or LFSR patterns to a C17 netlist,
// compacts the responses in a MISR and compares against a golden signature.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned SIG_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [NIN-1:0]   pat_o,
    input  logic [NOUT-1:0]  resp_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [IDX_W-1:0] pat_idx
);

    state_e             state_q, state_d;
    logic [NIN-1:0]     gen_q, gen_d;
    logic               mode_q, mode_d;
    logic [SIG_W-1:0]   golden_q, golden_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               misr_clr_c;
    logic               misr_en_c;
    logic               in_run_c;
    logic               last_c;
    logic [NIN-1:0]     gen_adv_c;
    logic [SIG_W-1:0]   sig_c;

    assign in_run_c  = state_q inside {ST_APPLY, ST_WAIT, ST_CAPTURE, ST_COMPARE};
    assign last_c    = idx_q == (mode_q ? IDX_W'(N_LFSR - 1) : IDX_W'(N_EXH - 1));
    assign gen_adv_c = mode_q ? lfsr_next(gen_q) : gen_q + NIN'(1);

    // Next-state and datapath control; abort overrides every in-run transition.
    always_comb begin
        state_d    = state_q;
        gen_d      = gen_q;
        mode_d     = mode_q;
        golden_d   = golden_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        misr_clr_c = 1'b0;
        misr_en_c  = 1'b0;

        if (in_run_c && abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        mode_d     = mode;
                        golden_d   = golden_sig;
                        gen_d      = mode ? LFSR_SEED : '0;
                        idx_d      = '0;
                        misr_clr_c = 1'b1;
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    wait_d  = CNT_W'(SETTLE - 1);
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        wait_d = wait_q - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    misr_en_c = 1'b1;
                    idx_d     = idx_q + IDX_W'(1);
                    // The final pattern stays on pat_o after the run.
                    if (last_c) begin
                        state_d = ST_COMPARE;
                    end else begin
                        gen_d   = gen_adv_c;
                        state_d = ST_APPLY;
                    end
                end
                ST_COMPARE: begin
                    pass_d  = (sig_c == golden_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gen_q    <= '0;
            mode_q   <= 1'b0;
            golden_q <= '0;
            idx_q    <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gen_q    <= gen_d;
            mode_q   <= mode_d;
            golden_q <= golden_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    c17_misr #(
        .W (SIG_W)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (misr_clr_c),
        .en_i   (misr_en_c),
        .data_i (resp_i),
        .sig_o  (sig_c)
    );

    assign pat_o     = gen_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_c;
    assign pat_idx   = idx_q;

endmodule
